uart_tx: RTL

- Serial transmit stage of the buffered UART. It sits directly downstream of the byte FIFO and drains it.
- While idle, it pops one byte whenever the FIFO is non-empty, captures the byte one cycle later, and shifts it out as an 8N1 frame on a single line, LSB first.
- Bit timing comes from a clock-cycle divisor.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
   localparam logic        UART_IDLE_LEVEL      = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divisor: tick marks the last clock of each bit period.
// clear restarts the period so a new frame starts on a clean boundary.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear || (count_q == LAST)) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign tick = (count_q == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a byte FIFO into 8N1 (or 8E1) frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_pop,
   output logic                  tx,
   output logic                  busy
);

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  tx_q, tx_d;
   logic                  pop_q, pop_d;
   logic                  busy_q;
   logic                  baud_clear;
   logic                  baud_tick;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock(clock),
      .reset(reset),
      .clear(baud_clear),
      .tick (baud_tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      tx_d       = tx_q;
      pop_d      = 1'b0;
      baud_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = UART_IDLE_LEVEL;
            if (!fifo_empty) begin
               pop_d   = 1'b1;
               state_d = FETCH;
            end
         end
         // The FIFO presents the popped byte during LOAD.
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d    = fifo_data;
            tx_d       = ~UART_IDLE_LEVEL;
            baud_clear = 1'b1;
            state_d    = START;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^fifo_data;
`endif
         end
         START: begin
            if (baud_tick) begin
               tx_d    = shift_q[0];
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (idx_q == LAST_BIT) begin
                  idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d    = UART_IDLE_LEVEL;
                  state_d = STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               tx_d    = UART_IDLE_LEVEL;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_tick) begin
               if (idx_q == LAST_STOP) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         tx_q     <= UART_IDLE_LEVEL;
         pop_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
         pop_q    <= pop_d;
         busy_q   <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign fifo_pop = pop_q;
   assign tx       = tx_q;
   assign busy     = busy_q;

endmodule
